ex_stage_mc: RTL and testbench
==============================

Name: ex_stage_mc

Overview:
Parametrised execute stage with a registered EX/MEM output boundary, a flag register with per-instruction write enable, and an iterative multi-cycle multiplier.
Single-cycle ALU ops complete in 1 cycle. MUL holds the stage busy and stalls upstream until it completes.
Sits between the ID/EX pipeline register and the MEM stage. Drives branch target, flags and result to MEM.

Parameters:
WIDTH, 16, datapath width; must be even and >= 8.
MUL_RBITS, 1, multiplier bits retired per cycle; one of 1, 2, 4; WIDTH % MUL_RBITS == 0.
SHW (localparam), $clog2(WIDTH), shift-amount width.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  asynchronous, active-low reset.
in_valid  in  1  instruction present.
in_op  in  4  ADD=0, SUB=1, NAND=2, XOR=3, MUL=4, SRA=5, SRL=6, SLL=7, LHB=A, LLB=B; others give result 0.
in_src_sel  in  2  B operand select: 00=in_b, 01=in_imm, 10=in_offset, 11=constant 1.
in_a, in_b, in_imm, in_offset, in_pc_inc  in  WIDTH  operands.
in_rd  in  4  destination register tag, passed through.
in_wb  in  2  WB control, passed through.
in_m  in  3  MEM control, passed through.
in_bcond  in  3  branch condition, passed through.
in_flag_we  in  1  instruction may update flags.
flush  in  1  synchronous kill.
busy  out  1  multiplier active; upstream must hold its instruction.
out_valid  out  1  output registers hold a completed instruction (1-cycle pulse per instruction).
out_result, out_pcbranch  out  WIDTH  registered result and branch target.
out_flags  out  3  {zr, neg, ov}, flag register.
out_rd  out  4  registered pass-through of in_rd.
out_wb  out  2  registered pass-through of in_wb.
out_m  out  3  registered pass-through of in_m.
out_bcond  out  3  registered pass-through of in_bcond.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, busy=0, out_valid=0, all out_* = 0, flags = 000, multiplier count and accumulators = 0. Reset during MUL discards the operation.
- FSM has two states, IDLE and MUL. busy = (state==MUL).
- Accept condition: in_valid && state==IDLE && !flush. in_valid is ignored while busy.
- Non-MUL op accepted at edge E:
  - result, pcbranch and pass-throughs are loaded at E.
  - out_valid=1 for the following cycle.
  - Latency is 1.
- MUL op accepted at edge E:
  - Latch A and B operands; state->MUL; cnt=0.
  - Each edge in MUL retires MUL_RBITS bits of the multiplier (shift-add); cnt++.
  - At the edge where cnt reaches WIDTH/MUL_RBITS-1: load out_* with the low WIDTH bits of the product, state->IDLE, out_valid=1 next cycle.
  - busy is high for WIDTH/MUL_RBITS cycles; total latency is WIDTH/MUL_RBITS + 1.
  - Pass-through fields are captured at accept time and presented with the result.
- out_valid deasserts the cycle after any edge that does not complete an instruction. out_* hold their last values while out_valid=0.
- Operation semantics, with H=WIDTH/2 and B = the operand chosen by in_src_sel:
  - ADD: a+B. SUB: a-B. NAND: ~(a&B). XOR: a^B. All wrap modulo 2^WIDTH.
  - SLL, SRL, SRA: shift a by in_imm[SHW-1:0]; SRA is arithmetic.
  - LHB: {B[H-1:0], a[H-1:0]}. LLB: {a[WIDTH-1:H], B[H-1:0]}.
- pcbranch = in_pc_inc + in_offset + 1, modulo 2^WIDTH. It is computed for every accepted instruction.
- Flags are written at completion only if the latched in_flag_we=1:
  - ADD/SUB: update zr, neg, ov.
    - ADD ov: a and B have equal signs, and the result sign differs.
    - SUB ov: a and B have differing signs, and the result sign differs from a.
  - NAND/XOR: update zr only; neg and ov hold.
  - MUL, shifts, LHB, LLB and undefined ops: flags hold.
- flush=1 at an edge:
  - Any MUL in progress is aborted and state->IDLE.
  - No instruction is accepted; out_valid=0 next cycle.
  - Flags and out_* data hold.
- A flush on the same edge as MUL completion takes precedence: no out_valid, flags hold.

Optional Feature:
EX_FWD_EN.
- Defined: adds ports in_rs, in_rt (in, 4), fwd_mem_we, fwd_wb_we (in, 1), fwd_mem_rd, fwd_wb_rd (in, 4), fwd_mem_data, fwd_wb_data (in, WIDTH).
  - Operand a = fwd_mem_data if fwd_mem_we && fwd_mem_rd==in_rs && in_rs!=0.
  - Otherwise a = fwd_wb_data under the same rule with the WB fields.
  - Otherwise a = in_a.
  - in_b is replaced the same way using in_rt, before the in_src_sel mux.
  - MEM always has priority over WB.
  - Forwarded values are sampled at the accept edge only.
- Undefined: these ports are absent; in_a and in_b are used directly.

Test Plan:
1. WIDTH=16, ADD a=0x7FFF, in_b=0x0001, src=00, flag_we=1 -> next cycle out_valid=1, result=0x8000, flags={0,1,1}; pcbranch = pc_inc+offset+1.
2. MUL a=0x0012, b=0x0034, MUL_RBITS=1 -> busy high 16 cycles, out_valid in cycle 17 with result=0x03A8; flags unchanged; in_valid held during busy is accepted only after busy falls.
3. MUL started, flush asserted on the 5th busy cycle -> busy=0 next cycle, no out_valid, flags hold; a following ADD 2+3 yields 0x0005 one cycle after accept.
4. SRA a=0x8000, imm=4, flag_we=1 -> result=0xF800, flags unchanged. LHB a=0x1234, imm=0x00AB, src=01 -> result=0xAB34.
5. rst low mid-MUL (cycle 8) -> busy, out_valid, out_*, flags all 0 immediately. After release, a SUB 0x8000-0x0001 gives 0x7FFF with ov=1, neg=0.
6. EX_FWD_EN defined, in_rs=3, MEM and WB both write r3 (0x1111 vs 0x2222) -> a=0x1111. With in_rs=0, in_a is used despite matching tags.

Source files
------------

// File: rtl/ex_stage_mc.sv
// Execute stage: single-cycle ALU, flag register, iterative shift-add multiplier.
// Latency: 1 cycle for ALU ops, WIDTH/MUL_RBITS+1 cycles for MUL (accept to out_valid).
// Backpressure: busy is high while a MUL iterates; upstream holds its instruction and in_valid is ignored.
//
// Ports: clk/rst (async active-low); in_* instruction fields from ID/EX; flush kills the
// in-flight MUL and blocks accept; out_* is the registered EX/MEM boundary.
// Optional macro EX_FWD_EN adds operand forwarding from the MEM and WB stages.
module ex_stage_mc #(
    parameter int WIDTH     = 16,
    parameter int MUL_RBITS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [3:0]       in_op,
    input  logic [1:0]       in_src_sel,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_imm,
    input  logic [WIDTH-1:0] in_offset,
    input  logic [WIDTH-1:0] in_pc_inc,
    input  logic [3:0]       in_rd,
    input  logic [1:0]       in_wb,
    input  logic [2:0]       in_m,
    input  logic [2:0]       in_bcond,
    input  logic             in_flag_we,
`ifdef EX_FWD_EN
    input  logic [3:0]       in_rs,
    input  logic [3:0]       in_rt,
    input  logic             fwd_mem_we,
    input  logic             fwd_wb_we,
    input  logic [3:0]       fwd_mem_rd,
    input  logic [3:0]       fwd_wb_rd,
    input  logic [WIDTH-1:0] fwd_mem_data,
    input  logic [WIDTH-1:0] fwd_wb_data,
`endif
    input  logic             flush,
    output logic             busy,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_result,
    output logic [WIDTH-1:0] out_pcbranch,
    output logic [2:0]       out_flags,
    output logic [3:0]       out_rd,
    output logic [1:0]       out_wb,
    output logic [2:0]       out_m,
    output logic [2:0]       out_bcond
);
    localparam int SHW   = $clog2(WIDTH);
    localparam int H     = WIDTH / 2;
    localparam int NSTEP = WIDTH / MUL_RBITS;
    localparam int CW    = $clog2(NSTEP);

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_NAND = 4'h2;
    localparam logic [3:0] OP_XOR  = 4'h3;
    localparam logic [3:0] OP_MUL  = 4'h4;
    localparam logic [3:0] OP_SRA  = 4'h5;
    localparam logic [3:0] OP_SRL  = 4'h6;
    localparam logic [3:0] OP_SLL  = 4'h7;
    localparam logic [3:0] OP_LHB  = 4'hA;
    localparam logic [3:0] OP_LLB  = 4'hB;

    typedef enum logic {S_IDLE, S_MUL} state_t;
    state_t state;

    logic [WIDTH-1:0] op_a, b_reg, op_b;
    logic [WIDTH-1:0] sum, diff, alu_res, pcb, pp, acc_nxt;
    logic [2:0]       flags_nxt;
    logic [SHW-1:0]   shamt;

    // Multiplier state: multiplicand shifts left, multiplier shifts right.
    logic [WIDTH-1:0] mul_a, mul_b, mul_acc;
    logic [CW-1:0]    cnt;

    // Fields captured at MUL accept, presented with the product.
    logic [WIDTH-1:0] hold_pcb;
    logic [3:0]       hold_rd;
    logic [1:0]       hold_wb;
    logic [2:0]       hold_m, hold_bcond;

    assign busy = (state == S_MUL);

    // Operand selection; MEM forwarding wins over WB, register 0 never forwards.
    always_comb begin
        op_a  = in_a;
        b_reg = in_b;
`ifdef EX_FWD_EN
        if (fwd_mem_we && fwd_mem_rd == in_rs && in_rs != 4'd0)
            op_a = fwd_mem_data;
        else if (fwd_wb_we && fwd_wb_rd == in_rs && in_rs != 4'd0)
            op_a = fwd_wb_data;
        if (fwd_mem_we && fwd_mem_rd == in_rt && in_rt != 4'd0)
            b_reg = fwd_mem_data;
        else if (fwd_wb_we && fwd_wb_rd == in_rt && in_rt != 4'd0)
            b_reg = fwd_wb_data;
`endif
        case (in_src_sel)
            2'b00:   op_b = b_reg;
            2'b01:   op_b = in_imm;
            2'b10:   op_b = in_offset;
            default: op_b = WIDTH'(1);
        endcase
    end

    assign sum   = op_a + op_b;
    assign diff  = op_a - op_b;
    assign shamt = in_imm[SHW-1:0];
    assign pcb   = in_pc_inc + in_offset + WIDTH'(1);

    // ALU result and candidate flags; flags_nxt defaults to hold.
    always_comb begin
        alu_res   = '0;
        flags_nxt = out_flags;
        case (in_op)
            OP_ADD: begin
                alu_res   = sum;
                flags_nxt = {sum == '0, sum[WIDTH-1],
                             (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1])};
            end
            OP_SUB: begin
                alu_res   = diff;
                flags_nxt = {diff == '0, diff[WIDTH-1],
                             (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1])};
            end
            OP_NAND: begin
                alu_res      = ~(op_a & op_b);
                flags_nxt[2] = (alu_res == '0);
            end
            OP_XOR: begin
                alu_res      = op_a ^ op_b;
                flags_nxt[2] = (alu_res == '0);
            end
            OP_SRA:  alu_res = WIDTH'($signed(op_a) >>> shamt);
            OP_SRL:  alu_res = op_a >> shamt;
            OP_SLL:  alu_res = op_a << shamt;
            OP_LHB:  alu_res = {op_b[H-1:0], op_a[H-1:0]};
            OP_LLB:  alu_res = {op_a[WIDTH-1:H], op_b[H-1:0]};
            default: alu_res = '0;
        endcase
    end

    // Partial product for the MUL_RBITS low multiplier bits this step.
    always_comb begin
        pp = '0;
        for (int j = 0; j < MUL_RBITS; j++)
            if (mul_b[j]) pp = pp + (mul_a << j);
    end
    assign acc_nxt = mul_acc + pp;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            out_valid    <= 1'b0;
            out_result   <= '0;
            out_pcbranch <= '0;
            out_flags    <= '0;
            out_rd       <= '0;
            out_wb       <= '0;
            out_m        <= '0;
            out_bcond    <= '0;
            mul_a        <= '0;
            mul_b        <= '0;
            mul_acc      <= '0;
            cnt          <= '0;
            hold_pcb     <= '0;
            hold_rd      <= '0;
            hold_wb      <= '0;
            hold_m       <= '0;
            hold_bcond   <= '0;
        end else begin
            out_valid <= 1'b0;
            if (flush) begin
                // Abort any MUL; completion on this same edge is also discarded.
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (in_valid) begin
                            if (in_op == OP_MUL) begin
                                mul_a      <= op_a;
                                mul_b      <= op_b;
                                mul_acc    <= '0;
                                cnt        <= '0;
                                hold_pcb   <= pcb;
                                hold_rd    <= in_rd;
                                hold_wb    <= in_wb;
                                hold_m     <= in_m;
                                hold_bcond <= in_bcond;
                                state      <= S_MUL;
                            end else begin
                                out_result   <= alu_res;
                                out_pcbranch <= pcb;
                                out_rd       <= in_rd;
                                out_wb       <= in_wb;
                                out_m        <= in_m;
                                out_bcond    <= in_bcond;
                                out_valid    <= 1'b1;
                                if (in_flag_we) out_flags <= flags_nxt;
                            end
                        end
                    end
                    S_MUL: begin
                        mul_acc <= acc_nxt;
                        mul_a   <= mul_a << MUL_RBITS;
                        mul_b   <= mul_b >> MUL_RBITS;
                        cnt     <= cnt + 1'b1;
                        if (cnt == CW'(NSTEP - 1)) begin
                            out_result   <= acc_nxt;
                            out_pcbranch <= hold_pcb;
                            out_rd       <= hold_rd;
                            out_wb       <= hold_wb;
                            out_m        <= hold_m;
                            out_bcond    <= hold_bcond;
                            out_valid    <= 1'b1;
                            state        <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ex_stage_mc.sv
// Directed bench for ex_stage_mc at WIDTH=16, MUL_RBITS=1.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled at the same point.
// Each task checks its own scenario inline against hand-computed values.
module tb_ex_stage_mc;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [3:0]   in_op;
    logic [1:0]   in_src_sel;
    logic [W-1:0] in_a, in_b, in_imm, in_offset, in_pc_inc;
    logic [3:0]   in_rd;
    logic [1:0]   in_wb;
    logic [2:0]   in_m, in_bcond;
    logic         in_flag_we;
    logic         flush;
    logic         busy, out_valid;
    logic [W-1:0] out_result, out_pcbranch;
    logic [2:0]   out_flags;
    logic [3:0]   out_rd;
    logic [1:0]   out_wb;
    logic [2:0]   out_m, out_bcond;
`ifdef EX_FWD_EN
    logic [3:0]   in_rs, in_rt, fwd_mem_rd, fwd_wb_rd;
    logic         fwd_mem_we, fwd_wb_we;
    logic [W-1:0] fwd_mem_data, fwd_wb_data;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    ex_stage_mc #(.WIDTH(W), .MUL_RBITS(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_op(in_op), .in_src_sel(in_src_sel),
        .in_a(in_a), .in_b(in_b), .in_imm(in_imm), .in_offset(in_offset), .in_pc_inc(in_pc_inc),
        .in_rd(in_rd), .in_wb(in_wb), .in_m(in_m), .in_bcond(in_bcond), .in_flag_we(in_flag_we),
`ifdef EX_FWD_EN
        .in_rs(in_rs), .in_rt(in_rt), .fwd_mem_we(fwd_mem_we), .fwd_wb_we(fwd_wb_we),
        .fwd_mem_rd(fwd_mem_rd), .fwd_wb_rd(fwd_wb_rd),
        .fwd_mem_data(fwd_mem_data), .fwd_wb_data(fwd_wb_data),
`endif
        .flush(flush), .busy(busy), .out_valid(out_valid), .out_result(out_result),
        .out_pcbranch(out_pcbranch), .out_flags(out_flags), .out_rd(out_rd), .out_wb(out_wb),
        .out_m(out_m), .out_bcond(out_bcond)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] imm, input logic [W-1:0] off, input logic [W-1:0] pc,
                          input logic [1:0] src, input logic fwe, input logic [3:0] rd);
        in_valid   = 1'b1;
        in_op      = op;
        in_a       = a;
        in_b       = b;
        in_imm     = imm;
        in_offset  = off;
        in_pc_inc  = pc;
        in_src_sel = src;
        in_flag_we = fwe;
        in_rd      = rd;
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", out_valid); else n_pass++;
        n_checks++; if (out_result !== 16'h0) $display("FAIL reset_result got %h exp 0000", out_result); else n_pass++;
        n_checks++; if (out_flags !== 3'b000) $display("FAIL reset_flags got %b exp 000", out_flags); else n_pass++;
        n_checks++; if (out_pcbranch !== 16'h0) $display("FAIL reset_pcb got %h exp 0000", out_pcbranch); else n_pass++;
        #11 rst = 1'b1;
        tick();
    endtask

    task automatic test_add();
        set_op(4'h0, 16'h7FFF, 16'h0001, 16'h0000, 16'h0020, 16'h0100, 2'b00, 1'b1, 4'd5);
        in_wb = 2'd2; in_m = 3'd3; in_bcond = 3'd4;
        tick();
        idle_in();
        n_checks++; if (out_valid !== 1'b1) $display("FAIL add_valid got %b exp 1", out_valid); else n_pass++;
        n_checks++; if (out_result !== 16'h8000) $display("FAIL add_result got %h exp 8000", out_result); else n_pass++;
        n_checks++; if (out_flags !== 3'b011) $display("FAIL add_flags got %b exp 011", out_flags); else n_pass++;
        n_checks++; if (out_pcbranch !== 16'h0121) $display("FAIL add_pcb got %h exp 0121", out_pcbranch); else n_pass++;
        n_checks++; if ({out_rd, out_wb, out_m, out_bcond} !== {4'd5, 2'd2, 3'd3, 3'd4})
            $display("FAIL add_pass got %h/%h/%h/%h exp 5/2/3/4", out_rd, out_wb, out_m, out_bcond); else n_pass++;
        tick();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL add_valid_drop got %b exp 0", out_valid); else n_pass++;
        n_checks++; if (out_result !== 16'h8000) $display("FAIL add_hold got %h exp 8000", out_result); else n_pass++;
    endtask

    // Back-to-back single-cycle ops, one accepted per cycle with in_valid held high.
    task automatic test_alu_ops();
        logic [3:0]   t_op  [13] = '{4'h0, 4'h2, 4'h3, 4'h1, 4'h7, 4'h6, 4'h5, 4'hA, 4'hB, 4'hC, 4'h0, 4'h1, 4'h3};
        logic [W-1:0] t_a   [13] = '{16'h7FFF, 16'hFFFF, 16'h00F0, 16'h0005, 16'h0003, 16'h8000, 16'h8000,
                                     16'h1234, 16'h1234, 16'h1234, 16'h7FFF, 16'h8000, 16'hFFFF};
        logic [W-1:0] t_b   [13] = '{16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                                     16'h0000, 16'h56AB, 16'h0001, 16'h0001, 16'h0001, 16'hFFFF};
        logic [W-1:0] t_imm [13] = '{16'h0, 16'h0, 16'h0, 16'h0005, 16'h0004, 16'h000F, 16'h0004,
                                     16'h00AB, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        logic [W-1:0] t_off [13] = '{16'h0010, 16'hFFFF, 16'h0010, 16'h0010, 16'h0010, 16'h0010, 16'h0010,
                                     16'h0010, 16'h0010, 16'h0010, 16'h0010, 16'h0010, 16'h0010};
        logic [1:0]   t_src [13] = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        logic         t_fwe [13] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [W-1:0] e_res [13] = '{16'h8000, 16'h0000, 16'h00F1, 16'h0000, 16'h0030, 16'h0001, 16'hF800,
                                     16'hAB34, 16'h12AB, 16'h0000, 16'h8000, 16'h7FFF, 16'h0000};
        logic [2:0]   e_flg [13] = '{3'b011, 3'b111, 3'b011, 3'b100, 3'b100, 3'b100, 3'b100,
                                     3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b101};
        logic [W-1:0] e_pcb [13] = '{16'h0111, 16'h0100, 16'h0111, 16'h0111, 16'h0111, 16'h0111, 16'h0111,
                                     16'h0111, 16'h0111, 16'h0111, 16'h0111, 16'h0111, 16'h0111};
        for (int i = 0; i < 13; i++) begin
            set_op(t_op[i], t_a[i], t_b[i], t_imm[i], t_off[i], 16'h0100, t_src[i], t_fwe[i], 4'(i));
            tick();
            n_checks++; if (out_valid !== 1'b1) $display("FAIL alu%0d_valid got %b exp 1", i, out_valid); else n_pass++;
            n_checks++; if (out_result !== e_res[i]) $display("FAIL alu%0d_result got %h exp %h", i, out_result, e_res[i]); else n_pass++;
            n_checks++; if (out_flags !== e_flg[i]) $display("FAIL alu%0d_flags got %b exp %b", i, out_flags, e_flg[i]); else n_pass++;
            n_checks++; if (out_pcbranch !== e_pcb[i]) $display("FAIL alu%0d_pcb got %h exp %h", i, out_pcbranch, e_pcb[i]); else n_pass++;
            n_checks++; if (out_rd !== 4'(i)) $display("FAIL alu%0d_rd got %0d exp %0d", i, out_rd, i); else n_pass++;
        end
        idle_in();
        tick();
    endtask

    task automatic test_mul();
        int cycles = 0;
        // Establish known flags (011) before the multiply.
        set_op(4'h0, 16'h7FFF, 16'h0001, 16'h0, 16'h0, 16'h0, 2'b00, 1'b1, 4'd0);
        tick();
        set_op(4'h4, 16'h0012, 16'h0034, 16'h0, 16'h0005, 16'h0010, 2'b00, 1'b1, 4'd9);
        tick();
        // Next instruction held at the input for the whole busy window.
        set_op(4'h0, 16'h0002, 16'h0003, 16'h0, 16'h0, 16'h0, 2'b00, 1'b0, 4'd1);
        while (busy === 1'b1 && cycles < 40) begin
            n_checks++; if (out_valid !== 1'b0) $display("FAIL mul_valid_early cycle %0d got %b exp 0", cycles, out_valid); else n_pass++;
            cycles++;
            tick();
        end
        n_checks++; if (cycles != 16) $display("FAIL mul_busy_cycles got %0d exp 16", cycles); else n_pass++;
        n_checks++; if (out_valid !== 1'b1) $display("FAIL mul_valid got %b exp 1", out_valid); else n_pass++;
        n_checks++; if (out_result !== 16'h03A8) $display("FAIL mul_result got %h exp 03a8", out_result); else n_pass++;
        n_checks++; if (out_flags !== 3'b011) $display("FAIL mul_flags got %b exp 011", out_flags); else n_pass++;
        n_checks++; if (out_rd !== 4'd9) $display("FAIL mul_rd got %0d exp 9", out_rd); else n_pass++;
        n_checks++; if (out_pcbranch !== 16'h0016) $display("FAIL mul_pcb got %h exp 0016", out_pcbranch); else n_pass++;
        tick();
        n_checks++; if (out_valid !== 1'b1) $display("FAIL mul_next_valid got %b exp 1", out_valid); else n_pass++;
        n_checks++; if (out_result !== 16'h0005) $display("FAIL mul_next_result got %h exp 0005", out_result); else n_pass++;
        n_checks++; if (out_rd !== 4'd1) $display("FAIL mul_next_rd got %0d exp 1", out_rd); else n_pass++;
        // Wraparound: only the low 16 bits of 0xFFFF*0xFFFF survive.
        set_op(4'h4, 16'hFFFF, 16'hFFFF, 16'h0, 16'h0, 16'h0, 2'b00, 1'b0, 4'd2);
        tick();
        idle_in();
        repeat (15) tick();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL mul2_valid_early got %b exp 0", out_valid); else n_pass++;
        tick();
        n_checks++; if (out_valid !== 1'b1) $display("FAIL mul2_valid got %b exp 1", out_valid); else n_pass++;
        n_checks++; if (out_result !== 16'h0001) $display("FAIL mul2_result got %h exp 0001", out_result); else n_pass++;
        tick();
    endtask

    task automatic test_flush();
        set_op(4'h4, 16'h0012, 16'h0034, 16'h0, 16'h0, 16'h0, 2'b00, 1'b1, 4'd3);
        tick();
        idle_in();
        repeat (4) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_checks++; if (busy !== 1'b0) $display("FAIL flush_busy got %b exp 0", busy); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL flush_valid got %b exp 0", out_valid); else n_pass++;
        n_checks++; if (out_result !== 16'h0001) $display("FAIL flush_hold got %h exp 0001", out_result); else n_pass++;
        n_checks++; if (out_flags !== 3'b011) $display("FAIL flush_flags got %b exp 011", out_flags); else n_pass++;
        repeat (14) tick();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL flush_no_late got %b exp 0", out_valid); else n_pass++;
        set_op(4'h0, 16'h0002, 16'h0003, 16'h0, 16'h0, 16'h0, 2'b00, 1'b1, 4'd4);
        tick();
        idle_in();
        n_checks++; if (out_valid !== 1'b1) $display("FAIL flush_add_valid got %b exp 1", out_valid); else n_pass++;
        n_checks++; if (out_result !== 16'h0005) $display("FAIL flush_add_result got %h exp 0005", out_result); else n_pass++;
        n_checks++; if (out_flags !== 3'b000) $display("FAIL flush_add_flags got %b exp 000", out_flags); else n_pass++;
        // Flush on the accept edge blocks the instruction.
        set_op(4'h0, 16'h0001, 16'h0001, 16'h0, 16'h0, 16'h0, 2'b00, 1'b1, 4'd6);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle_in();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL flush_accept_valid got %b exp 0", out_valid); else n_pass++;
        n_checks++; if (out_result !== 16'h0005) $display("FAIL flush_accept_hold got %h exp 0005", out_result); else n_pass++;
        // Flush on the completion edge wins over the result.
        set_op(4'h4, 16'h0012, 16'h0034, 16'h0, 16'h0, 16'h0, 2'b00, 1'b1, 4'd7);
        tick();
        idle_in();
        repeat (15) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL flush_done_valid got %b exp 0", out_valid); else n_pass++;
        n_checks++; if (out_result !== 16'h0005) $display("FAIL flush_done_hold got %h exp 0005", out_result); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL flush_done_busy got %b exp 0", busy); else n_pass++;
    endtask

    task automatic test_reset_mid_mul();
        // Nonzero flags first so the reset clear is observable.
        set_op(4'h0, 16'h7FFF, 16'h0001, 16'h0, 16'h0, 16'h0, 2'b00, 1'b1, 4'd8);
        tick();
        set_op(4'h4, 16'h0012, 16'h0034, 16'h0, 16'h0, 16'h0, 2'b00, 1'b1, 4'd9);
        tick();
        idle_in();
        repeat (7) tick();
        #2 rst = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL rmul_busy got %b exp 0", busy); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rmul_valid got %b exp 0", out_valid); else n_pass++;
        n_checks++; if (out_result !== 16'h0) $display("FAIL rmul_result got %h exp 0000", out_result); else n_pass++;
        n_checks++; if (out_flags !== 3'b000) $display("FAIL rmul_flags got %b exp 000", out_flags); else n_pass++;
        n_checks++; if (out_rd !== 4'd0) $display("FAIL rmul_rd got %0d exp 0", out_rd); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        tick();
        n_checks++; if (busy !== 1'b0 || out_valid !== 1'b0) $display("FAIL rmul_after got busy=%b valid=%b exp 0/0", busy, out_valid); else n_pass++;
        set_op(4'h1, 16'h8000, 16'h0001, 16'h0, 16'h0, 16'h0, 2'b00, 1'b1, 4'd2);
        tick();
        idle_in();
        n_checks++; if (out_result !== 16'h7FFF) $display("FAIL rmul_sub_result got %h exp 7fff", out_result); else n_pass++;
        n_checks++; if (out_flags !== 3'b001) $display("FAIL rmul_sub_flags got %b exp 001", out_flags); else n_pass++;
        tick();
    endtask

`ifdef EX_FWD_EN
    task automatic test_fwd();
        fwd_mem_we = 1'b1; fwd_mem_rd = 4'd3; fwd_mem_data = 16'h1111;
        fwd_wb_we  = 1'b1; fwd_wb_rd  = 4'd3; fwd_wb_data  = 16'h2222;
        in_rs = 4'd3; in_rt = 4'd0;
        set_op(4'h0, 16'h0AAA, 16'h0000, 16'h0, 16'h0, 16'h0, 2'b11, 1'b0, 4'd1);
        tick();
        n_checks++; if (out_result !== 16'h1112) $display("FAIL fwd_mem got %h exp 1112", out_result); else n_pass++;
        fwd_mem_we = 1'b0;
        tick();
        n_checks++; if (out_result !== 16'h2223) $display("FAIL fwd_wb got %h exp 2223", out_result); else n_pass++;
        fwd_mem_we = 1'b1;
        in_rs = 4'd0; fwd_mem_rd = 4'd0; fwd_wb_rd = 4'd0;
        tick();
        n_checks++; if (out_result !== 16'h0AAB) $display("FAIL fwd_r0 got %h exp 0aab", out_result); else n_pass++;
        fwd_mem_rd = 4'd3; in_rt = 4'd3; in_src_sel = 2'b00;
        tick();
        idle_in();
        n_checks++; if (out_result !== 16'h1BBB) $display("FAIL fwd_rt got %h exp 1bbb", out_result); else n_pass++;
        fwd_mem_we = 1'b0; fwd_wb_we = 1'b0;
        tick();
    endtask
`endif

    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = 4'h0; in_src_sel = 2'b00;
        in_a = '0; in_b = '0; in_imm = '0; in_offset = '0; in_pc_inc = '0;
        in_rd = '0; in_wb = '0; in_m = '0; in_bcond = '0; in_flag_we = 1'b0;
`ifdef EX_FWD_EN
        in_rs = '0; in_rt = '0; fwd_mem_we = 1'b0; fwd_wb_we = 1'b0;
        fwd_mem_rd = '0; fwd_wb_rd = '0; fwd_mem_data = '0; fwd_wb_data = '0;
`endif
        test_reset();
        test_add();
        test_alu_ops();
        test_mul();
        test_flush();
        test_reset_mid_mul();
`ifdef EX_FWD_EN
        test_fwd();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
